// File: rtl/tick_event_scheduler.sv
// Shared-prescaler multi-channel timer with round-robin expiry event stream.
// Optional sticky per-channel overrun flags: define TICK_SCHED_OVERRUN_EN.
module tick_event_scheduler #(
   parameter int CLK_RATE   = 100_000_000,
   parameter int DIV_FACTOR = 2,
   parameter int NUM_CH     = 4,
   parameter int PERIOD_W   = 16,
   localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   output logic                base_tick,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CH_W-1:0]     cfg_ch,
   input  logic [PERIOD_W-1:0] cfg_period,
   input  logic                cfg_oneshot,
   output logic                evt_valid,
   input  logic                evt_ready,
   output logic [CH_W-1:0]     evt_ch,
   output logic [NUM_CH-1:0]   ch_active
`ifdef TICK_SCHED_OVERRUN_EN
   ,
   output logic [NUM_CH-1:0]   overrun,
   input  logic [NUM_CH-1:0]   ovr_clr
`endif
);

   localparam int PRESCALE = CLK_RATE / DIV_FACTOR;
   localparam int PS_W     = $clog2(PRESCALE);
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} ch_state_t;

   logic [PS_W-1:0]     ps_cnt;
   ch_state_t           ch_state  [NUM_CH];
   logic [PERIOD_W-1:0] period    [NUM_CH];
   logic [PERIOD_W-1:0] remaining [NUM_CH];
   logic [NUM_CH-1:0]   oneshot;
   logic [NUM_CH-1:0]   pending;
   logic [NUM_CH-1:0]   cfg_hit;
   logic [NUM_CH-1:0]   expire;
   logic [NUM_CH-1:0]   hs_clr;
   logic [NUM_CH-1:0]   cand;
   logic [CH_W-1:0]     rr_ptr;
   logic [CH_W-1:0]     next_ch;
   logic [CH_W-1:0]     start;
   logic [CH_W-1:0]     sel;
   logic [CH_W-1:0]     idx;
   logic [CH_W:0]       sum;
   logic                sel_found;
   logic                hs;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ps_cnt    <= '0;
         base_tick <= 1'b0;
      end else begin
         base_tick <= 1'b0;
         if (en) begin
            if (ps_cnt == PS_LAST) begin
               ps_cnt    <= '0;
               base_tick <= 1'b1;
            end else begin
               ps_cnt <= ps_cnt + PS_W'(1);
            end
         end
      end
   end

   assign hs      = evt_valid && evt_ready;
   assign hs_clr  = hs ? (NUM_CH'(1) << evt_ch) : '0;
   assign next_ch = (evt_ch == CH_W'(NUM_CH - 1)) ? '0 : evt_ch + CH_W'(1);

   // A config write to a channel masks that channel's tick in the same cycle.
   always_comb begin
      cfg_hit   = '0;
      expire    = '0;
      ch_active = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         cfg_hit[i]   = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
         expire[i]    = base_tick && (ch_state[i] == RUN) &&
                        (remaining[i] == PERIOD_W'(1)) && !cfg_hit[i];
         ch_active[i] = (ch_state[i] == RUN);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            ch_state[i]  <= IDLE;
            period[i]    <= '0;
            remaining[i] <= '0;
         end
         oneshot   <= '0;
         pending   <= '0;
         cfg_ready <= 1'b0;
      end else begin
         cfg_ready <= 1'b1;
         // A fresh expiry survives a same-cycle handoff of that channel.
         pending   <= (pending & ~hs_clr) | expire;
         for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_hit[i]) begin
               if (cfg_period == '0) begin
                  ch_state[i] <= IDLE;
               end else begin
                  period[i]    <= cfg_period;
                  remaining[i] <= cfg_period;
                  oneshot[i]   <= cfg_oneshot;
                  ch_state[i]  <= RUN;
               end
            end else if (base_tick && (ch_state[i] == RUN)) begin
               if (remaining[i] > PERIOD_W'(1)) begin
                  remaining[i] <= remaining[i] - PERIOD_W'(1);
               end else if (oneshot[i]) begin
                  ch_state[i] <= IDLE;
               end else begin
                  remaining[i] <= period[i];
               end
            end
         end
      end
   end

   // Round-robin pick of the first pending channel from the pointer onward.
   always_comb begin
      start     = hs ? next_ch : rr_ptr;
      cand      = pending & ~hs_clr;
      sel       = '0;
      sel_found = 1'b0;
      sum       = '0;
      idx       = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         sum = {1'b0, start} + (CH_W+1)'(k);
         if (sum >= (CH_W+1)'(NUM_CH)) sum = sum - (CH_W+1)'(NUM_CH);
         idx = sum[CH_W-1:0];
         if (!sel_found && cand[idx]) begin
            sel_found = 1'b1;
            sel       = idx;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         evt_valid <= 1'b0;
         evt_ch    <= '0;
         rr_ptr    <= '0;
      end else begin
         if (hs) rr_ptr <= next_ch;
         if (!evt_valid || hs) begin
            evt_valid <= sel_found;
            if (sel_found) evt_ch <= sel;
         end
      end
   end

`ifdef TICK_SCHED_OVERRUN_EN
   logic [NUM_CH-1:0] lost;
   assign lost = expire & pending & ~hs_clr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) overrun <= '0;
      else     overrun <= (overrun & ~ovr_clr) | lost;
   end
`else
   // Lost expiries leave pending set and are otherwise dropped.
`endif

endmodule

// File: tb/tb_tick_event_scheduler.sv
// Directed bench for tick_event_scheduler with PRESCALE=10, four channels.
// Inputs change #1 after posedge; outputs are sampled on negedge.
module tb_tick_event_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       base_tick;
   logic       cfg_valid = 1'b0;
   logic       cfg_ready;
   logic [1:0] cfg_ch = '0;
   logic [7:0] cfg_period = '0;
   logic       cfg_oneshot = 1'b0;
   logic       evt_valid;
   logic       evt_ready = 1'b1;
   logic [1:0] evt_ch;
   logic [3:0] ch_active;
`ifdef TICK_SCHED_OVERRUN_EN
   logic [3:0] overrun;
   logic [3:0] ovr_clr = '0;
`endif

   tick_event_scheduler #(
      .CLK_RATE   (100),
      .DIV_FACTOR (10),
      .NUM_CH     (4),
      .PERIOD_W   (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .base_tick   (base_tick),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_ch      (cfg_ch),
      .cfg_period  (cfg_period),
      .cfg_oneshot (cfg_oneshot),
      .evt_valid   (evt_valid),
      .evt_ready   (evt_ready),
      .evt_ch      (evt_ch),
      .ch_active   (ch_active)
`ifdef TICK_SCHED_OVERRUN_EN
      ,
      .overrun     (overrun),
      .ovr_clr     (ovr_clr)
`endif
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int hs_cnt = 0;
   logic [1:0] exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time exceeded, required finish earlier");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk = n_chk + 1;
      if (act !== req) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %0d required %0d (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // Scoreboard: every accepted event is popped against the expected queue.
   always @(negedge clk) begin
      if (!rst && evt_valid && evt_ready) begin
         hs_cnt = hs_cnt + 1;
         n_chk = n_chk + 1;
         if (exp_q.size() == 0) begin
            n_err = n_err + 1;
            $display("FAIL evt_unexpected: got ch %0d required no event (cycle %0d)", evt_ch, cyc);
         end else begin
            logic [1:0] e;
            e = exp_q.pop_front();
            if (evt_ch !== e) begin
               n_err = n_err + 1;
               $display("FAIL evt_order: got ch %0d required ch %0d (cycle %0d)", evt_ch, e, cyc);
            end
         end
      end
   end

   task automatic wait_tick(output int t);
      t = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (base_tick) begin
            t = cyc;
            break;
         end
      end
      if (t < 0) begin
         n_chk = n_chk + 1;
         n_err = n_err + 1;
         $display("FAIL tick_timeout: got no base_tick in 40 cycles required one (cycle %0d)", cyc);
      end
   endtask

   task automatic drv_cfg(input logic [1:0] ch, input logic [7:0] per, input logic os);
      @(posedge clk); #1;
      cfg_valid   = 1'b1;
      cfg_ch      = ch;
      cfg_period  = per;
      cfg_oneshot = os;
      @(posedge clk); #1;
      cfg_valid   = 1'b0;
   endtask

   typedef struct {
      logic [1:0] ch;
      logic [7:0] period;
      logic       oneshot;
      logic [3:0] exp_active;
   } cfg_vec_t;

   cfg_vec_t tbl [6];

   initial begin
      int c0, t, tp, hs0;
      logic [7:0] per;

      tbl[0] = '{2'd0, 8'd200, 1'b0, 4'b0001};
      tbl[1] = '{2'd2, 8'd200, 1'b1, 4'b0101};
      tbl[2] = '{2'd3, 8'd150, 1'b0, 4'b1101};
      tbl[3] = '{2'd2, 8'd0,   1'b0, 4'b1001};
      tbl[4] = '{2'd0, 8'd0,   1'b1, 4'b1000};
      tbl[5] = '{2'd3, 8'd0,   1'b0, 4'b0000};

      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_base_tick", base_tick, 0);
      chk("rst_cfg_ready", cfg_ready, 0);
      chk("rst_evt_valid", evt_valid, 0);
      chk("rst_evt_ch", evt_ch, 0);
      chk("rst_ch_active", ch_active, 0);

      // Prescaler cadence and en freeze
      @(posedge clk); #1;
      rst = 1'b0;
      en  = 1'b1;
      c0  = cyc;
      wait_tick(t);
      chk("tick_first", t - c0, 10);
      for (int i = 0; i < 2; i++) begin
         tp = t;
         wait_tick(t);
         chk("tick_interval", t - tp, 10);
      end
      tp = t;
      @(posedge clk); #1;
      en = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      en = 1'b1;
      wait_tick(t);
      chk("tick_en_hold", t - tp, 15);

      // Config table: ch_active follows each write
      for (int i = 0; i < 6; i++) begin
         per = tbl[i].period;
         if (per != 0) per = 8'($urandom_range(100, 255));
         drv_cfg(tbl[i].ch, per, tbl[i].oneshot);
         @(negedge clk);
         chk("tbl_ch_active", ch_active, tbl[i].exp_active);
         chk("tbl_cfg_ready", cfg_ready, 1);
      end

      // Periodic ch0, period 3
      wait_tick(t);
      drv_cfg(2'd0, 8'd3, 1'b0);
      @(negedge clk);
      chk("p3_ch_active", ch_active, 4'b0001);
      tp = 0;
      for (int e = 0; e < 3; e++) begin
         exp_q.push_back(2'd0);
         for (int j = 0; j < 3; j++) wait_tick(t);
         @(negedge clk);
         chk("p3_early", evt_valid, 0);
         @(negedge clk);
         chk("p3_valid", evt_valid, 1);
         chk("p3_ch", evt_ch, 0);
         if (e > 0) chk("p3_period", t - tp, 30);
         tp = t;
      end
      drv_cfg(2'd0, 8'd0, 1'b0);
      @(negedge clk);
      chk("p3_stop", ch_active, 0);

      // Simultaneous expiry of ch1 and ch3 under backpressure
      wait_tick(t);
      @(posedge clk); #1;
      evt_ready = 1'b0;
      drv_cfg(2'd1, 8'd2, 1'b1);
      drv_cfg(2'd3, 8'd2, 1'b1);
      @(negedge clk);
      chk("rr_ch_active", ch_active, 4'b1010);
      wait_tick(t);
      wait_tick(t);
      exp_q.push_back(2'd1);
      exp_q.push_back(2'd3);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("rr_hold_valid", evt_valid, 1);
         chk("rr_hold_ch", evt_ch, 1);
      end
      @(posedge clk); #1;
      evt_ready = 1'b1;
      @(negedge clk);
      chk("rr_first", {evt_valid, evt_ch}, {1'b1, 2'd1});
      @(negedge clk);
      chk("rr_second", {evt_valid, evt_ch}, {1'b1, 2'd3});
      @(negedge clk);
      chk("rr_drained", evt_valid, 0);
      chk("rr_ptr", dut.rr_ptr, 0);
      chk("rr_ch_active", ch_active, 0);

      // One-shot ch2, period 1
      wait_tick(t);
      drv_cfg(2'd2, 8'd1, 1'b1);
      exp_q.push_back(2'd2);
      wait_tick(t);
      chk("os_active", ch_active, 4'b0100);
      @(negedge clk);
      chk("os_active_fall", ch_active, 0);
      chk("os_early", evt_valid, 0);
      @(negedge clk);
      chk("os_evt", {evt_valid, evt_ch}, {1'b1, 2'd2});
      #1;
      hs0 = hs_cnt;
      repeat (100) @(negedge clk);
      #1;
      chk("os_no_repeat", hs_cnt - hs0, 0);

      // Lost expiries while the consumer stalls
      wait_tick(t);
      @(posedge clk); #1;
      evt_ready = 1'b0;
      drv_cfg(2'd0, 8'd1, 1'b0);
      repeat (40) @(negedge clk);
      chk("ovr_held", {evt_valid, evt_ch}, {1'b1, 2'd0});
`ifdef TICK_SCHED_OVERRUN_EN
      chk("ovr_set", overrun, 4'b0001);
`endif
      drv_cfg(2'd0, 8'd0, 1'b0);
      @(negedge clk);
      chk("ovr_stopped", ch_active, 0);
`ifdef TICK_SCHED_OVERRUN_EN
      @(posedge clk); #1;
      ovr_clr = 4'b0001;
      @(posedge clk); #1;
      ovr_clr = 4'b0000;
      @(negedge clk);
      chk("ovr_cleared", overrun, 0);
`endif
      exp_q.push_back(2'd0);
      @(posedge clk); #1;
      hs0 = hs_cnt;
      evt_ready = 1'b1;
      repeat (30) @(negedge clk);
      #1;
      chk("ovr_one_event", hs_cnt - hs0, 1);

      // Reset mid-countdown with an event held
      wait_tick(t);
      @(posedge clk); #1;
      evt_ready = 1'b0;
      drv_cfg(2'd1, 8'd1, 1'b0);
      drv_cfg(2'd2, 8'd5, 1'b0);
      wait_tick(t);
      repeat (3) @(negedge clk);
      chk("mrst_pre_valid", {evt_valid, evt_ch}, {1'b1, 2'd1});
      #2;
      rst = 1'b1;
      #1;
      chk("mrst_outputs", {base_tick, cfg_ready, evt_valid, evt_ch, ch_active}, 0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      c0 = cyc;
      wait_tick(t);
      chk("mrst_tick", t - c0, 10);
      @(posedge clk); #1;
      hs0 = hs_cnt;
      evt_ready = 1'b1;
      repeat (60) @(negedge clk);
      #1;
      chk("mrst_no_stale", hs_cnt - hs0, 0);
      chk("mrst_idle", {evt_valid, ch_active}, 0);
      chk("sb_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
